// File: rtl/arp_rx_parser_if.sv
// Receive byte stream bundle feeding the ARP parser.
// The MAC-side receiver is the master; the parser is the slave.
interface arp_rx_parser_if;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxSof;
  logic       RxEof;
  logic       RxErr;

  modport master (
    output RxData,
    output RxValid,
    output RxSof,
    output RxEof,
    output RxErr
  );

  modport slave (
    input RxData,
    input RxValid,
    input RxSof,
    input RxEof,
    input RxErr
  );
endinterface

// File: rtl/arp_rx_parser.sv
// ARP receive parser: checks an Ethernet/ARP frame byte by byte and
// pulses on requests for LocalIP or replies from PeerIP.
module arp_rx_parser #(
  parameter bit CHECK_DST_MAC = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  arp_rx_parser_if.slave        rx,
  input  logic [47:0]           LocalMAC,
  input  logic [31:0]           LocalIP,
  input  logic [31:0]           PeerIP,
  output logic                  ARPReqReced,
  output logic                  ARPReplyReced,
  output logic [47:0]           RecDstMacAddr,
  output logic [31:0]           RecSrcIP
);

  typedef enum logic [1:0] {
    IDLE,
    PARSE,
    WAIT_EOF,
    DROP
  } state_t;

  state_t      state;
  logic [1:0]  rstQ;
  logic        rstN;
  logic [5:0]  cnt;
  logic [5:0]  cntNext;
  logic [5:0]  idx;
  logic [7:0]  d;
  logic        parsing;
  logic        bcastR;
  logic        localR;
  logic        bcastN;
  logic        localN;
  logic        operReq;
  logic [7:0]  macByte;
  logic        fieldBad;
  logic [47:0] shaSh;
  logic [31:0] spaSh;
  logic [31:0] tpaSh;
  logic [31:0] tpaN;
  logic        eofHit;
  logic        accept;
  logic        hitReq;
  logic        hitRep;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstQ <= 2'b00;
    end else begin
      rstQ <= {rstQ[0], 1'b1};
    end
  end

  assign rstN = rstQ[1];

  assign d       = rx.RxData;
  assign parsing = rx.RxSof || (state == PARSE);
  assign idx     = rx.RxSof ? 6'd0 : cnt;
  assign cntNext = rx.RxSof ? 6'd1 :
                   (cnt == 6'd63) ? cnt : cnt + 6'd1;

  always_comb begin
    macByte = LocalMAC[7:0];
    case (idx[2:0])
      3'd0:    macByte = LocalMAC[47:40];
      3'd1:    macByte = LocalMAC[39:32];
      3'd2:    macByte = LocalMAC[31:24];
      3'd3:    macByte = LocalMAC[23:16];
      3'd4:    macByte = LocalMAC[15:8];
      default: macByte = LocalMAC[7:0];
    endcase
  end

  always_comb begin
    bcastN = bcastR;
    localN = localR;
    if (idx < 6'd6) begin
      bcastN = ((idx == 6'd0) || bcastR) && (d == 8'hFF);
      localN = ((idx == 6'd0) || localR) && (d == macByte);
    end
  end

  always_comb begin
    fieldBad = 1'b0;
    unique case (1'b1)
      idx < 6'd6:  fieldBad = CHECK_DST_MAC && !(bcastN || localN);
      idx == 6'd12: fieldBad = (d != 8'h08);
      idx == 6'd13: fieldBad = (d != 8'h06);
      idx == 6'd14: fieldBad = (d != 8'h00);
      idx == 6'd15: fieldBad = (d != 8'h01);
      idx == 6'd16: fieldBad = (d != 8'h08);
      idx == 6'd17: fieldBad = (d != 8'h00);
      idx == 6'd18: fieldBad = (d != 8'h06);
      idx == 6'd19: fieldBad = (d != 8'h04);
      idx == 6'd20: fieldBad = (d != 8'h00);
      idx == 6'd21: fieldBad = (d != 8'h01) && (d != 8'h02);
      default:      fieldBad = 1'b0;
    endcase
  end

  // TPA's last byte may arrive on the EOF beat itself.
  assign tpaN = (parsing && idx >= 6'd38 && idx <= 6'd41) ?
                {tpaSh[23:0], d} : tpaSh;

  assign eofHit = rx.RxValid && rx.RxEof && !rx.RxSof &&
                  ((state == WAIT_EOF) ||
                   (state == PARSE && !fieldBad && idx == 6'd41));
  assign accept = eofHit && !rx.RxErr && (tpaN == LocalIP);
  assign hitReq = accept && operReq;
  assign hitRep = accept && !operReq && (spaSh == PeerIP);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      cnt           <= 6'd0;
      bcastR        <= 1'b0;
      localR        <= 1'b0;
      operReq       <= 1'b0;
      shaSh         <= 48'h0;
      spaSh         <= 32'h0;
      tpaSh         <= 32'h0;
      ARPReqReced   <= 1'b0;
      ARPReplyReced <= 1'b0;
      RecDstMacAddr <= 48'h0;
      RecSrcIP      <= 32'h0;
    end else begin
      ARPReqReced   <= hitReq;
      ARPReplyReced <= hitRep;
      if (hitReq || hitRep) begin
        RecDstMacAddr <= shaSh;
        RecSrcIP      <= spaSh;
      end
      if (rx.RxValid && (rx.RxSof || state != IDLE)) begin
        cnt <= cntNext;
        if (parsing) begin
          bcastR <= bcastN;
          localR <= localN;
          tpaSh  <= tpaN;
          if (idx == 6'd21) begin
            operReq <= (d == 8'h01);
          end
          if (idx >= 6'd22 && idx <= 6'd27) begin
            shaSh <= {shaSh[39:0], d};
          end
          if (idx >= 6'd28 && idx <= 6'd31) begin
            spaSh <= {spaSh[23:0], d};
          end
        end
        if (rx.RxSof && rx.RxEof) begin
          state <= IDLE;
        end else if (parsing) begin
          if (fieldBad) begin
            state <= rx.RxEof ? IDLE : DROP;
          end else if (rx.RxEof) begin
            state <= IDLE;
          end else if (idx == 6'd41) begin
            state <= WAIT_EOF;
          end else begin
            state <= PARSE;
          end
        end else if (rx.RxEof) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_rx_parser.sv
// Directed bench for arp_rx_parser: vector table of whole frames
// plus hand sequences for runts, aborts, gaps and reset.
module tb_arp_rx_parser;

  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] LM  = 48'h0200_0000_0001;
  localparam logic [47:0] OTH = 48'h0200_0000_0099;
  localparam logic [47:0] SRC = 48'h0266_7788_99AA;
  localparam logic [31:0] LIP = 32'hC0A8_0A02;
  localparam logic [31:0] PIP = 32'hC0A8_0A64;

  logic        clk;
  logic        rst;
  logic        ARPReqReced;
  logic        ARPReplyReced;
  logic [47:0] RecDstMacAddr;
  logic [31:0] RecSrcIP;

  arp_rx_parser_if rxIf ();

  arp_rx_parser #(.CHECK_DST_MAC(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rxIf),
    .LocalMAC     (LM),
    .LocalIP      (LIP),
    .PeerIP       (PIP),
    .ARPReqReced  (ARPReqReced),
    .ARPReplyReced(ARPReplyReced),
    .RecDstMacAddr(RecDstMacAddr),
    .RecSrcIP     (RecSrcIP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] et;
    logic [15:0] op;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    int          len;
    bit          err;
    bit          eReq;
    bit          eRep;
    logic [47:0] eMac;
    logic [31:0] eIp;
  } vec_t;

  vec_t       v [10];
  logic [7:0] fb [0:63];
  int         nCmp = 0;
  int         nBad = 0;
  int         reqTot = 0;
  int         repTot = 0;
  int         expReq = 0;
  int         expRep = 0;
  bit         both = 1'b0;

  always @(negedge clk) begin
    if (ARPReqReced) reqTot++;
    if (ARPReplyReced) repTot++;
    if (ARPReqReced && ARPReplyReced) both = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkOut(input string nm, input bit rq, input bit rp,
                        input logic [47:0] mac, input logic [31:0] ip);
    chk({nm, " req"}, {63'h0, ARPReqReced}, {63'h0, rq});
    chk({nm, " rep"}, {63'h0, ARPReplyReced}, {63'h0, rp});
    chk({nm, " mac"}, {16'h0, RecDstMacAddr}, {16'h0, mac});
    chk({nm, " ip"}, {32'h0, RecSrcIP}, {32'h0, ip});
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et,
                       input logic [15:0] op, input logic [47:0] sha,
                       input logic [31:0] spa, input logic [31:0] tpa);
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]      = dst[47-8*i -: 8];
      fb[6 + i]  = SRC[47-8*i -: 8];
      fb[22 + i] = sha[47-8*i -: 8];
    end
    fb[12] = et[15:8];
    fb[13] = et[7:0];
    fb[14] = 8'h00;
    fb[15] = 8'h01;
    fb[16] = 8'h08;
    fb[17] = 8'h00;
    fb[18] = 8'h06;
    fb[19] = 8'h04;
    fb[20] = op[15:8];
    fb[21] = op[7:0];
    for (int i = 0; i < 4; i++) begin
      fb[28 + i] = spa[31-8*i -: 8];
      fb[38 + i] = tpa[31-8*i -: 8];
    end
  endtask

  task automatic idleBus();
    rxIf.RxValid = 1'b0;
    rxIf.RxSof   = 1'b0;
    rxIf.RxEof   = 1'b0;
    rxIf.RxErr   = 1'b0;
  endtask

  task automatic sendBytes(input int first, input int last, input bit eof,
                           input bit err, input int gapMax);
    for (int i = first; i <= last; i++) begin
      rxIf.RxData  = fb[i];
      rxIf.RxValid = 1'b1;
      rxIf.RxSof   = (i == 0);
      rxIf.RxEof   = eof && (i == last);
      rxIf.RxErr   = err && (i == last);
      @(posedge clk); #1;
      idleBus();
      if (i < last && gapMax > 0) begin
        repeat ($urandom_range(gapMax, 0)) begin
          rxIf.RxData = 8'($urandom);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    v[0] = '{BC, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0A64,
             LIP, 60, 0, 1, 0, 48'h0011_2233_4455, 32'hC0A8_0A64};
    v[1] = '{LM, 16'h0806, 16'h0002, 48'hAABB_CCDD_EEFF, 32'hC0A8_0A64,
             LIP, 60, 0, 0, 1, 48'hAABB_CCDD_EEFF, 32'hC0A8_0A64};
    v[2] = '{LM, 16'h0806, 16'h0002, 48'h1122_3344_5566, 32'hC0A8_0A65,
             LIP, 60, 0, 0, 0, 48'hAABB_CCDD_EEFF, 32'hC0A8_0A64};
    v[3] = '{BC, 16'h0806, 16'h0001, 48'h1212_1212_1212, 32'h0A0A_0A0A,
             LIP, 60, 1, 0, 0, 48'hAABB_CCDD_EEFF, 32'hC0A8_0A64};
    v[4] = '{BC, 16'h0800, 16'h0001, 48'h3434_3434_3434, 32'h0B0B_0B0B,
             LIP, 60, 0, 0, 0, 48'hAABB_CCDD_EEFF, 32'hC0A8_0A64};
    v[5] = '{BC, 16'h0806, 16'h0001, 48'h5656_5656_5656, 32'h0C0C_0C0C,
             32'hC0A8_0A03, 60, 0, 0, 0, 48'hAABB_CCDD_EEFF, 32'hC0A8_0A64};
    v[6] = '{OTH, 16'h0806, 16'h0001, 48'h7878_7878_7878, 32'h0D0D_0D0D,
             LIP, 60, 0, 0, 0, 48'hAABB_CCDD_EEFF, 32'hC0A8_0A64};
    v[7] = '{LM, 16'h0806, 16'h0001, 48'h0102_0304_0506, 32'h0A00_0001,
             LIP, 42, 0, 1, 0, 48'h0102_0304_0506, 32'h0A00_0001};
    v[8] = '{BC, 16'h0806, 16'h0003, 48'h9A9A_9A9A_9A9A, 32'h0E0E_0E0E,
             LIP, 60, 0, 0, 0, 48'h0102_0304_0506, 32'h0A00_0001};
    v[9] = '{BC, 16'h0806, 16'h0002, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0A64,
             LIP, 64, 0, 0, 1, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0A64};

    rxIf.RxData = 8'h00;
    idleBus();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chkOut("reset", 0, 0, 48'h0, 32'h0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int k = 0; k < 10; k++) begin
      build(v[k].dst, v[k].et, v[k].op, v[k].sha, v[k].spa, v[k].tpa);
      sendBytes(0, v[k].len - 1, 1, v[k].err, 0);
      chkOut($sformatf("vec%0d", k), v[k].eReq, v[k].eRep,
             v[k].eMac, v[k].eIp);
      expReq += int'(v[k].eReq);
      expRep += int'(v[k].eRep);
      @(posedge clk); #1;
      chk($sformatf("vec%0d req1cyc", k), {63'h0, ARPReqReced}, 64'h0);
      chk($sformatf("vec%0d rep1cyc", k), {63'h0, ARPReplyReced}, 64'h0);
      repeat (2) @(posedge clk);
      #1;
    end

    build(BC, 16'h0806, 16'h0001, 48'h1111_1111_1111, 32'h0A0A_0A10, LIP);
    sendBytes(0, 30, 1, 0, 0);
    chkOut("runt30", 0, 0, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0A64);
    sendBytes(0, 19, 0, 0, 0);
    build(BC, 16'h0806, 16'h0001, 48'h3333_3333_3333, 32'h0A0A_0A33, LIP);
    sendBytes(0, 59, 1, 0, 0);
    chkOut("abort", 1, 0, 48'h3333_3333_3333, 32'h0A0A_0A33);
    expReq += 1;
    @(posedge clk); #1;
    sendBytes(0, 0, 1, 0, 0);
    chkOut("sofeof", 0, 0, 48'h3333_3333_3333, 32'h0A0A_0A33);
    repeat (2) @(posedge clk);
    #1;

    build(BC, 16'h0806, 16'h0001, 48'h4455_6677_8899, 32'hC0A8_0A07, LIP);
    sendBytes(0, 59, 1, 0, 5);
    chkOut("gapreq", 1, 0, 48'h4455_6677_8899, 32'hC0A8_0A07);
    expReq += 1;
    build(LM, 16'h0806, 16'h0002, 48'hCAFE_BABE_0001, PIP, LIP);
    sendBytes(0, 41, 1, 0, 0);
    chkOut("b2brep", 0, 1, 48'hCAFE_BABE_0001, PIP);
    expRep += 1;
    repeat (2) @(posedge clk);
    #1;

    build(BC, 16'h0806, 16'h0001, 48'h5A5A_5A5A_5A5A, 32'h0A00_0005, LIP);
    sendBytes(0, 24, 0, 0, 0);
    rxIf.RxData  = fb[25];
    rxIf.RxValid = 1'b1;
    rst = 1'b0;
    #1;
    chkOut("inrst", 0, 0, 48'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    idleBus();
    chkOut("inrst2", 0, 0, 48'h0, 32'h0);
    rst = 1'b1;
    sendBytes(31, 59, 1, 0, 0);
    chkOut("stray", 0, 0, 48'h0, 32'h0);
    build(BC, 16'h0806, 16'h0001, 48'h6B6B_6B6B_6B6B, 32'h0A00_0006, LIP);
    sendBytes(0, 59, 1, 0, 0);
    chkOut("postrst", 1, 0, 48'h6B6B_6B6B_6B6B, 32'h0A00_0006);
    expReq += 1;
    repeat (3) @(posedge clk);
    #1;

    chk("reqTotal", 64'(reqTot), 64'(expReq));
    chk("repTotal", 64'(repTot), 64'(expRep));
    chk("mutex", {63'h0, both}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/arp_rx_parser.md
ARP_RX_PARSER -- requirements
Module: arp_rx_parser

Interface
REQ-001 The block SHALL have parameter CHECK_DST_MAC, default 1, meaning: 1 accepts only frames with destination MAC equal to broadcast or LocalMAC; 0 accepts any destination MAC.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port RxData, input, 8 bits: receive byte stream, starting at the destination MAC, with no preamble and no FCS.
REQ-005 The block SHALL have port RxValid, input, 1 bit: RxData is valid on this beat.
REQ-006 The block SHALL have port RxSof, input, 1 bit: first byte of a frame; meaningful only with RxValid.
REQ-007 The block SHALL have port RxEof, input, 1 bit: last byte of a frame; meaningful only with RxValid.
REQ-008 The block SHALL have port RxErr, input, 1 bit: bad-FCS flag, sampled on the RxEof beat.
REQ-009 The block SHALL have port LocalMAC, input, 48 bits: own MAC address, quasi-static.
REQ-010 The block SHALL have port LocalIP, input, 32 bits: own IP address, quasi-static.
REQ-011 The block SHALL have port PeerIP, input, 32 bits: data destination IP, the address whose reply is awaited.
REQ-012 The block SHALL have port ARPReqReced, output, 1 bit: one-cycle pulse on a valid ARP request addressed to LocalIP.
REQ-013 The block SHALL have port ARPReplyReced, output, 1 bit: one-cycle pulse on a valid ARP reply from PeerIP.
REQ-014 The block SHALL have port RecDstMacAddr, output, 48 bits: sender MAC (SHA) of the last accepted ARP packet; held between updates.
REQ-015 The block SHALL have port RecSrcIP, output, 32 bits: sender IP (SPA) of the last accepted ARP packet; held between updates.

Function
REQ-016 The frame byte offsets SHALL be: 0-5 destination MAC; 6-11 source MAC; 12-13 EtherType; 14-15 HTYPE; 16-17 PTYPE; 18 HLEN; 19 PLEN; 20-21 OPER; 22-27 SHA; 28-31 SPA; 32-37 THA; 38-41 TPA; 42 and above padding (ignored).
REQ-017 The byte counter SHALL be 6 bits, advance only on RxValid beats, and saturate at 63 with no wrap.
REQ-018 The state machine SHALL have states IDLE, PARSE, WAIT_EOF and DROP.
REQ-019 IDLE transitions: RxValid && RxSof -> PARSE with the counter set to 1 and byte 0 checked; all other beats are ignored.
REQ-020 PARSE SHALL perform field checks on their beats: EtherType 0x0806; HTYPE 0x0001; PTYPE 0x0800; HLEN 0x06; PLEN 0x04; OPER 0x0001 or 0x0002; destination MAC per CHECK_DST_MAC.
REQ-021 On any field-check mismatch, PARSE SHALL go to DROP.
REQ-022 SHA, SPA and TPA SHALL be captured into shadow registers; the outputs SHALL NOT change during parsing.
REQ-023 PARSE SHALL go to WAIT_EOF after byte 41 is accepted.
REQ-024 RxEof before byte 41 (runt frame) SHALL cause PARSE -> IDLE with no pulse.
REQ-025 DROP SHALL consume beats until RxEof, then go to IDLE with no pulse.
REQ-026 On the RxEof beat (byte 41 or later), the block SHALL evaluate the accept conditions: RxErr=0, all field checks passed, TPA==LocalIP.
REQ-027 If the accept conditions hold and OPER=1, the block SHALL pulse ARPReqReced.
REQ-028 If the accept conditions hold, OPER=2 and SPA==PeerIP, the block SHALL pulse ARPReplyReced.
REQ-029 An accepted frame SHALL return the block to IDLE.
REQ-030 Pulses SHALL be exactly 1 cycle, asserted on the cycle after the RxEof beat.
REQ-031 On the pulse cycle, RecDstMacAddr SHALL be loaded from the SHA shadow and RecSrcIP from the SPA shadow.
REQ-032 Frames that are dropped or rejected SHALL NOT change RecDstMacAddr or RecSrcIP.
REQ-033 RxValid=0 beats SHALL stall parsing without state change, for unbounded duration.
REQ-034 RxSof while in PARSE, WAIT_EOF or DROP SHALL abort the current frame silently and restart parsing with this byte as byte 0.
REQ-035 RxSof and RxEof on the same beat SHALL be treated as a 1-byte runt: no pulse, next state IDLE.
REQ-036 ARPReqReced and ARPReplyReced SHALL be mutually exclusive.
REQ-037 Back-to-back frames, where the next RxSof arrives on the cycle after RxEof, SHALL both be parsed correctly; the pulse of frame N SHALL NOT be lost.
REQ-038 LocalIP, LocalMAC and PeerIP SHALL be sampled on the RxEof beat and compared against live values.

Reset
REQ-039 While rst=0, state SHALL be IDLE, the counter 0, the shadows 0, ARPReqReced=0, ARPReplyReced=0, RecDstMacAddr=48'h0, RecSrcIP=32'h0.
REQ-040 Reset asserted mid-frame SHALL discard the frame; after release, bytes SHALL be ignored until the next RxSof.
REQ-041 Reset deassertion SHALL be synchronised to clk internally.

Verification
REQ-042 Scenario: broadcast ARP request, TPA=LocalIP=C0A80A02, SHA=00_11_22_33_44_55, SPA=C0A80A64, padded to 60 bytes, RxErr=0 -> one ARPReqReced pulse the cycle after RxEof; RecDstMacAddr=001122334455; RecSrcIP=C0A80A64.
REQ-043 Scenario: unicast reply to LocalMAC, OPER=2, SPA=PeerIP=C0A80A64, SHA=AA_BB_CC_DD_EE_FF -> one ARPReplyReced pulse; RecDstMacAddr=AABBCCDDEEFF. Same frame with SPA=C0A80A65 -> no pulse, outputs unchanged.
REQ-044 Scenario: valid request with RxErr=1 on the RxEof beat, or EtherType=0x0800 -> no pulse, outputs unchanged, block accepts the next frame normally.
REQ-045 Scenario: request frame ending with RxEof at byte 30 (runt), then RxSof at byte 20 of a frame followed by a full valid request -> exactly one ARPReqReced pulse, for the second frame only.
REQ-046 Scenario: valid request with random RxValid gaps of 0-5 cycles, followed by a back-to-back valid reply -> ARPReqReced pulse, then ARPReplyReced pulse, with RecDstMacAddr updated in order.
REQ-047 Scenario: rst=0 asserted at byte 25 of a valid request, released, then a full valid request sent -> all outputs 0 during reset; a single pulse for the post-reset frame only.
